alu16: RTL and testbench
========================

# alu16

Registered 16-bit signed ALU for the datapath: takes two 16-bit operands and a 4-bit opcode, and produces a 16-bit result, a 16-bit high/auxiliary word and three status flags. It sits between the register file and the write-back mux. Multiply and divide results span the `out`/`hi` pair.

## Interface
- No parameters; data width is fixed at 16, opcode width at 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `out` output 16: signed primary result, registered.
- `flags` output 3: registered status flags.
  - `flags[2]` = overflow.
  - `flags[1]` = negative, equal to `out[15]`.
  - `flags[0]` = zero, set when `out == 0`.
- `hi` output 16: signed high product or remainder, registered.
- `A` input 16: operand A, two's complement.
- `B` input 16: operand B, two's complement.
- `ins` input 4: opcode.

## Operation
- 0 NOP: out=0, hi=0.
- 1 ADD: out=A+B. Overflow = signed overflow.
- 2 SUB: out=A−B. Overflow = signed overflow.
- 3 MUL: signed 32-bit product. {hi,out} = A*B. Overflow set when the product does not fit in signed 16 bits.
- 4 DIV: signed, truncating toward zero.
  - out = quotient; hi = remainder, which takes the sign of A.
  - B==0: out=16'hFFFF, hi=A, overflow=1.
  - A=−32768 and B=−1: out=−32768, hi=0, overflow=1.
- 5 AND: out=A&B.
- 6 OR: out=A|B.
- 7 XOR: out=A^B.
- 8 NOT: out=~A.
- 9 SHL: out=A<<B[3:0], logical left shift; zero fill.
- 10–15 reserved: out=0, hi=0, flags=3'b001.
- For opcodes other than MUL and DIV, hi=0 and overflow=0 except where stated above.
- Negative and zero flags always derive from the 16-bit `out` value being registered.

## Timing
- Combinational result computed from the current A, B, ins. It is captured into `out`, `hi`, `flags` on every rising `clk`.
- Latency is 1 cycle: inputs present before edge k appear on the outputs after edge k. Throughput is 1 operation per cycle, with no handshake and no stall.
- `rst_n` low clears out, hi and flags to 0 immediately, independent of `clk`. Outputs hold 0 while reset is asserted.
  - The first capture is the first rising edge after `rst_n` deasserts.
  - Reset asserted mid-stream discards the in-flight result.
- Inputs changing between edges have no effect until the next edge.
- Division is single-cycle combinational; no multi-cycle divider.

## Configuration
- `ALU_MULDIV_EN` defined: opcodes 3 and 4 behave as specified above.
- Not defined: multiplier and divider are not built. Opcodes 3 and 4 behave as reserved (out=0, hi=0, flags=3'b001).

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants: OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL;
  - flag bit indices: FLAG_OVF=2, FLAG_NEG=1, FLAG_ZERO=0;
  - width constant DATA_W=16.
- One sub-module, `alu16_comb`, holds the purely combinational opcode decode and arithmetic.
- Top `alu16` contains only the output registers with the async reset.

## Test plan
- Reset: drive `rst_n`=0 with nonzero inputs → out=0, hi=0, flags=000 without a clock edge. After release, the first edge loads the result.
- A=511, B=3, ins=1..9 on successive cycles → outputs one cycle later:
  - ADD: out=514.
  - SUB: out=508.
  - MUL: out=1533, hi=0.
  - DIV: out=170, hi=1.
  - AND: out=3.
  - OR: out=511.
  - XOR: out=508.
  - NOT: out=−512, flags=010.
  - SHL: out=4088.
  - All cases above have hi=0 except as listed, and flags=000 except NOT.
- Overflow cases:
  - ADD 32767+1 → out=−32768, flags=110.
  - MUL 300*300 → {hi,out}=90000, i.e. hi=1, out=24464, flags=100.
- DIV edge cases:
  - −7/2 → out=−3, hi=−1.
  - A=5, B=0 → out=−1, hi=5, flags=110.
  - −32768/−1 → out=−32768, hi=0, flags=110.
- Zero and reserved:
  - SUB 5−5 → out=0, flags=001.
  - ins=12 → out=0, hi=0, flags=001.
  - Build without `ALU_MULDIV_EN`: ins=3 → flags=001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and width definitions for the alu16 datapath block.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 3;

    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_NEG  = 1;
    localparam int unsigned FLAG_ZERO = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOT = 4'd8,
        OP_SHL = 4'd9
    } opcode_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] hi;
        logic [FLAG_W-1:0] flags;
    } alu_res_t;

endpackage

// File: rtl/alu16_comb.sv
// Combinational opcode decode and arithmetic for alu16.
// Multiply/divide are built only when ALU_MULDIV_EN is defined; otherwise opcodes 3/4 decode as reserved.
module alu16_comb
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   ins,
    output alu_res_t          res_c
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] hi;
    logic              ovf;

    assign sum  = a + b;
    assign diff = a - b;

`ifdef ALU_MULDIV_EN
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   quot;
    logic signed [DATA_W-1:0]   rem;
    logic                       div_by_zero;
    logic                       div_ovf;

    assign prod        = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    assign div_by_zero = (b == '0);
    assign div_ovf     = (a == 16'h8000) && (b == 16'hFFFF);

    // Guard the divider so the zero and overflow cases never reach the operator.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (!div_by_zero && !div_ovf) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end
`endif

    always_comb begin
        result = '0;
        hi     = '0;
        ovf    = 1'b0;
        case (ins)
            OP_NOP: result = '0;
            OP_ADD: begin
                result = sum;
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                result = prod[DATA_W-1:0];
                hi     = prod[2*DATA_W-1:DATA_W];
                // Fits in 16 bits only if the upper 17 bits are a pure sign extension.
                ovf    = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
            end
            OP_DIV: begin
                if (div_by_zero) begin
                    result = 16'hFFFF;
                    hi     = a;
                    ovf    = 1'b1;
                end else if (div_ovf) begin
                    result = 16'h8000;
                    hi     = '0;
                    ovf    = 1'b1;
                end else begin
                    result = quot;
                    hi     = rem;
                end
            end
`endif
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: result = a << b[3:0];
            default: begin
                result = '0;
                hi     = '0;
                ovf    = 1'b0;
            end
        endcase
    end

    always_comb begin
        res_c                  = '0;
        res_c.result           = result;
        res_c.hi               = hi;
        res_c.flags[FLAG_OVF]  = ovf;
        res_c.flags[FLAG_NEG]  = result[DATA_W-1];
        res_c.flags[FLAG_ZERO] = (result == '0);
    end

endmodule

// File: rtl/alu16.sv
// Registered 16-bit signed ALU: one-cycle latency, async active-low reset clears all outputs.
// Optional multiply/divide enabled by ALU_MULDIV_EN (see alu16_comb).
module alu16
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] out,
    output logic [FLAG_W-1:0] flags,
    output logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   ins
);

    alu_res_t res_d;
    alu_res_t res_q;

    alu16_comb u_comb (
        .a     (A),
        .b     (B),
        .ins   (ins),
        .res_c (res_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign out   = res_q.result;
    assign hi    = res_q.hi;
    assign flags = res_q.flags;

endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16: stimulus pushes expected results, a monitor pops and compares after each edge.
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic [15:0] out;
    logic [2:0]  flags;
    logic [15:0] hi;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ins;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [15:0] hi;
        logic [2:0]  flags;
    } exp_t;

    exp_t exp_q[$];

    alu16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .out   (out),
        .flags (flags),
        .hi    (hi),
        .A     (A),
        .B     (B),
        .ins   (ins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [15:0] eo, input logic [15:0] eh,
                             input logic [2:0] ef);
        check16({nm, ".out"}, out, eo);
        check16({nm, ".hi"}, hi, eh);
        check16({nm, ".flags"}, 16'(flags), 16'(ef));
    endtask

    task automatic push_exp(input string nm, input logic [15:0] eo, input logic [15:0] eh,
                            input logic [2:0] ef);
        exp_t e;
        e.name  = nm;
        e.out   = eo;
        e.hi    = eh;
        e.flags = ef;
        exp_q.push_back(e);
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eo, input logic [15:0] eh,
                         input logic [2:0] ef);
        @(negedge clk);
        A   = a;
        B   = b;
        ins = op;
        push_exp(nm, eo, eh, ef);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: one result appears per edge for each entry queued before that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                #1;
                check_all(e.name, e.out, e.hi, e.flags);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        A     = 16'h1234;
        B     = 16'h0056;
        ins   = 4'd1;
        #3;
        check_all("reset_no_clk", 16'h0000, 16'h0000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held", 16'h0000, 16'h0000, 3'b000);

        // First edge after release captures the inputs already present.
        @(negedge clk);
        rst_n = 1'b1;
        push_exp("first_edge", 16'h128A, 16'h0000, 3'b000);

        issue("add",  4'd1, 16'd511, 16'd3, 16'd514,  16'd0, 3'b000);
        issue("sub",  4'd2, 16'd511, 16'd3, 16'd508,  16'd0, 3'b000);
`ifdef ALU_MULDIV_EN
        issue("mul",  4'd3, 16'd511, 16'd3, 16'd1533, 16'd0, 3'b000);
        issue("div",  4'd4, 16'd511, 16'd3, 16'd170,  16'd1, 3'b000);
`else
        issue("mul_rsv", 4'd3, 16'd511, 16'd3, 16'd0, 16'd0, 3'b001);
        issue("div_rsv", 4'd4, 16'd511, 16'd3, 16'd0, 16'd0, 3'b001);
`endif
        issue("and",  4'd5, 16'd511, 16'd3, 16'd3,    16'd0, 3'b000);
        issue("or",   4'd6, 16'd511, 16'd3, 16'd511,  16'd0, 3'b000);
        issue("xor",  4'd7, 16'd511, 16'd3, 16'd508,  16'd0, 3'b000);
        issue("not",  4'd8, 16'd511, 16'd3, 16'hFE00, 16'd0, 3'b010);
        issue("shl",  4'd9, 16'd511, 16'd3, 16'd4088, 16'd0, 3'b000);

        issue("add_ovf",  4'd1, 16'h7FFF, 16'h0001, 16'h8000, 16'd0, 3'b110);
        issue("sub_ovf",  4'd2, 16'h8000, 16'h0001, 16'h7FFF, 16'd0, 3'b100);
        issue("sub_zero", 4'd2, 16'd5,    16'd5,    16'h0000, 16'd0, 3'b001);
        issue("shl_b4",   4'd9, 16'h0001, 16'h00F3, 16'h0008, 16'd0, 3'b000);
        issue("nop",      4'd0, 16'h1111, 16'h2222, 16'h0000, 16'd0, 3'b001);
        issue("rsv12",    4'd12, 16'h1111, 16'h2222, 16'h0000, 16'd0, 3'b001);
        issue("rsv15",    4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 16'd0, 3'b001);
`ifdef ALU_MULDIV_EN
        issue("mul_ovf",  4'd3, 16'd300,  16'd300,  16'd24464, 16'd1,    3'b100);
        issue("mul_neg",  4'd3, 16'hFFFE, 16'd3,    16'hFFFA,  16'hFFFF, 3'b010);
        issue("div_neg",  4'd4, 16'hFFF9, 16'd2,    16'hFFFD,  16'hFFFF, 3'b010);
        issue("div_zero", 4'd4, 16'd5,    16'd0,    16'hFFFF,  16'd5,    3'b110);
        issue("div_ovf",  4'd4, 16'h8000, 16'hFFFF, 16'h8000,  16'd0,    3'b110);
`else
        issue("mul_ovf_rsv",  4'd3, 16'd300, 16'd300, 16'd0, 16'd0, 3'b001);
        issue("div_zero_rsv", 4'd4, 16'd5,   16'd0,   16'd0, 16'd0, 3'b001);
`endif
        issue("not_zero", 4'd8, 16'h0000, 16'h0000, 16'hFFFF, 16'd0, 3'b010);
        drain();

        // Mid-stream reset discards the operation set up before the next edge.
        @(negedge clk);
        A   = 16'd1;
        B   = 16'd1;
        ins = 4'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midreset_async", 16'h0000, 16'h0000, 3'b000);
        @(posedge clk);
        #1;
        check_all("midreset_edge", 16'h0000, 16'h0000, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        A     = 16'h00F0;
        B     = 16'h0FF0;
        ins   = 4'd7;
        push_exp("post_reset_xor", 16'h0F00, 16'd0, 3'b000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
